// File: rtl/f1_sop.sv
// Registered leaf function cell: evaluates a fixed 4-input truth table from
// dual-rail inputs, holds the result on rail faults and counts faulty cycles.
module f1_sop #(
   parameter logic [15:0] TRUTH_TABLE = 16'h1DB1,
   parameter int unsigned ERR_CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a,
   input  logic                 a2,
   input  logic                 b,
   input  logic                 b2,
   input  logic                 c,
   input  logic                 c2,
   input  logic                 d,
   input  logic                 d2,
   output logic                 out,
   output logic                 rail_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

   logic [3:0] pair_ok;
   logic       valid;
   logic       fault;
   logic [3:0] idx;
   logic       f_next;
   logic       cnt_sat;

   // A rail pair is healthy only when its two wires disagree.
   assign pair_ok = {a ^ a2, b ^ b2, c ^ c2, d ^ d2};
   assign valid   = &pair_ok;
   assign fault   = ~valid;

   // Only the true rails address the table; complements serve the check.
   assign idx     = {a, b, c, d};
   assign f_next  = TRUTH_TABLE[idx];
   assign cnt_sat = &err_cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out      <= 1'b0;
         rail_err <= 1'b0;
         err_cnt  <= '0;
      end else begin
         // NOTE: omitting an else inside a clocked block is a clock enable,
         // not a latch; out deliberately keeps its last good value on a fault.
         if (valid) begin
            out <= f_next;
         end
         rail_err <= fault;
         if (fault && !cnt_sat) begin
            err_cnt <= err_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_f1_sop.sv
// Self-checking bench for f1_sop: directed table vectors, corner sequences and
// randomized dual-rail stimulus against a minterm-list reference model.
module tb_f1_sop;

   localparam int CW      = 8;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a, a2, b, b2, c, c2, d, d2;
   logic          out, rail_err;
   logic [CW-1:0] err_cnt;
   logic          out_hi, rail_err_hi;
   logic [CW-1:0] err_cnt_hi;

   always #5 clk = ~clk;

   f1_sop #(.TRUTH_TABLE(16'h1DB1), .ERR_CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a(a), .a2(a2), .b(b), .b2(b2), .c(c), .c2(c2), .d(d), .d2(d2),
      .out(out), .rail_err(rail_err), .err_cnt(err_cnt)
   );

   f1_sop #(.TRUTH_TABLE(16'h8000), .ERR_CNT_W(CW)) dut_hi (
      .clk(clk), .rst_n(rst_n),
      .a(a), .a2(a2), .b(b), .b2(b2), .c(c), .c2(c2), .d(d), .d2(d2),
      .out(out_hi), .rail_err(rail_err_hi), .err_cnt(err_cnt_hi)
   );

   typedef struct {
      logic [3:0] abcd;
      logic       exp_out;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_out, m_out_hi, m_err, m_cnt;
   int minterms[$] = '{0, 4, 5, 7, 8, 10, 11, 12};

   function automatic int f_default(input int i);
      foreach (minterms[k]) if (minterms[k] == i) return 1;
      return 0;
   endfunction

   function automatic int f_hi(input int i);
      return (i == 15) ? 1 : 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_out"}, int'(out), m_out);
      check({tag, "_rail_err"}, int'(rail_err), m_err);
      check({tag, "_err_cnt"}, int'(err_cnt), m_cnt);
      check({tag, "_out_hi"}, int'(out_hi), m_out_hi);
      check({tag, "_err_cnt_hi"}, int'(err_cnt_hi), m_cnt);
   endtask

   task automatic model_reset();
      m_out = 0; m_out_hi = 0; m_err = 0; m_cnt = 0;
   endtask

   // t = true rails {a,b,c,d}, cr = complement rails {a2,b2,c2,d2}
   task automatic step(input logic [3:0] t, input logic [3:0] cr, input string tag);
      {a, b, c, d}     = t;
      {a2, b2, c2, d2} = cr;
      #1;
      check({tag, "_no_comb_path"}, int'(out), m_out);
      @(posedge clk);
      if ((t ^ cr) == 4'hF) begin
         m_out    = f_default(int'(t));
         m_out_hi = f_hi(int'(t));
         m_err    = 0;
      end else begin
         m_err = 1;
         if (m_cnt < CNT_MAX) m_cnt++;
      end
      #1;
      check_all(tag);
   endtask

   task automatic step_valid(input logic [3:0] t, input string tag);
      step(t, ~t, tag);
   endtask

   vec_t gray[16];

   initial begin
      gray[0]  = '{4'b0000, 1'b1}; gray[1]  = '{4'b1000, 1'b1};
      gray[2]  = '{4'b1100, 1'b1}; gray[3]  = '{4'b0100, 1'b1};
      gray[4]  = '{4'b0110, 1'b0}; gray[5]  = '{4'b1110, 1'b0};
      gray[6]  = '{4'b1010, 1'b1}; gray[7]  = '{4'b0010, 1'b0};
      gray[8]  = '{4'b0011, 1'b0}; gray[9]  = '{4'b1011, 1'b1};
      gray[10] = '{4'b1111, 1'b0}; gray[11] = '{4'b0111, 1'b1};
      gray[12] = '{4'b0101, 1'b1}; gray[13] = '{4'b1101, 1'b0};
      gray[14] = '{4'b1001, 1'b0}; gray[15] = '{4'b0001, 1'b0};

      // Power-on reset
      rst_n = 1'b0;
      {a, b, c, d} = 4'b0000; {a2, b2, c2, d2} = 4'b1111;
      model_reset();
      #1;
      check_all("por");
      repeat (2) @(posedge clk);
      #1;
      check_all("por_held");
      @(negedge clk) rst_n = 1'b1;

      // Gray-code walk with valid rails
      for (int i = 0; i < 16; i++) begin
         step_valid(gray[i].abcd, "gray");
         check("gray_table_out", int'(out), int'(gray[i].exp_out));
         check("gray_rail_err", int'(rail_err), 0);
      end

      // Single-pair fault: a=a2=1 for three cycles after valid 0100
      step_valid(4'b0100, "pre_fault");
      check("pre_fault_out", int'(out), 1);
      for (int i = 0; i < 3; i++) step(4'b1100, 4'b1011, "fault_a");
      check("fault_hold_out", int'(out), 1);
      check("fault_rail_err", int'(rail_err), 1);
      check("fault_err_cnt", int'(err_cnt), 3);
      step_valid(4'b1100, "restore");
      check("restore_out", int'(out), 1);
      check("restore_rail_err", int'(rail_err), 0);

      // Asynchronous reset mid-run, asserted away from any clock edge
      check("pre_reset_cnt", int'(err_cnt), 3);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_out", int'(out), 0);
      check("async_rst_rail_err", int'(rail_err), 0);
      check("async_rst_err_cnt", int'(err_cnt), 0);
      repeat (2) @(posedge clk);
      #1;
      check_all("rst_held");
      @(negedge clk) rst_n = 1'b1;

      // Multi-pair fault in one cycle counts once
      step_valid(4'b0000, "pre_multi");
      step(4'b0001, 4'b1011, "multi");
      check("multi_err_cnt", int'(err_cnt), 1);
      check("multi_hold_out", int'(out), 1);
      step_valid(4'b1111, "post_multi");
      check("hi_only_1111", int'(out_hi), 1);

      // Randomized dual-rail stimulus, about one pair in eight faulty
      for (int n = 0; n < 300; n++) begin
         logic [3:0] t, cr;
         t = 4'($urandom_range(0, 15));
         cr = ~t;
         for (int k = 0; k < 4; k++)
            if ($urandom_range(0, 7) == 0) cr[k] = t[k];
         step(t, cr, "rand");
      end

      // Saturation from a fresh count
      @(negedge clk) rst_n = 1'b0;
      model_reset();
      #1;
      check_all("sat_rst");
      @(negedge clk) rst_n = 1'b1;
      for (int n = 0; n < 300; n++) step(4'b0101, 4'b0000, "sat");
      check("sat_err_cnt", int'(err_cnt), CNT_MAX);
      step_valid(4'b0101, "sat_recover");
      check("sat_recover_rail_err", int'(rail_err), 0);
      check("sat_recover_cnt", int'(err_cnt), CNT_MAX);
      check("sat_recover_out", int'(out), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
